// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

    typedef enum logic {IDLE, SEND} tx_arb_state_t;

    localparam int FRAME_BITS_DEFAULT = 10;
    localparam int BYTE_W             = 8;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or after
// the pointer, wrapping around the request vector.
module uart_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   pointer,
    output logic             valid,
    output logic [IDW-1:0]   index
);

    logic [2*N_REQ-1:0] doubled;
    logic [N_REQ-1:0]   rotated;
    logic [IDW:0]       sum;

    // Rotate the request vector so that bit 0 is the requester at the pointer.
    assign doubled = {req, req};
    assign rotated = doubled[pointer +: N_REQ];

    // Scan from the highest offset down so the lowest set offset wins, then
    // map that offset back to an absolute requester index modulo N_REQ.
    always_comb begin
        valid = 1'b0;
        sum   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                valid = 1'b1;
                sum   = {1'b0, pointer} + (IDW+1)'(k);
            end
        end
        if (sum >= (IDW+1)'(N_REQ)) begin
            sum = sum - (IDW+1)'(N_REQ);
        end
        index = sum[IDW-1:0];
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one tx_fsm transmitter among N_REQ byte
// requesters. Since tx_fsm has no busy/done, the frame length is timed here.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int N_REQ        = 4,
    parameter  int CLKS_PER_BIT = 10,
    parameter  int FRAME_BITS   = FRAME_BITS_DEFAULT,
    localparam int IDW          = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int FRAME_CYCLES = FRAME_BITS * CLKS_PER_BIT,
    localparam int CNT_W        = $clog2(FRAME_CYCLES + 1)
) (
    input  logic                          clk,
    input  logic                          RST,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ-1:0][BYTE_W-1:0]  req_data,
    output logic [N_REQ-1:0]              ack,
    output logic                          tx_start,
    output logic [BYTE_W-1:0]             tx_data,
    output logic                          busy,
    output logic [IDW-1:0]                grant_id
);

    tx_arb_state_t  state;
    logic [CNT_W-1:0] cnt;
    logic [IDW-1:0] rr_ptr;
    logic           pick_valid;
    logic [IDW-1:0] pick_idx;
    logic [IDW:0]   ptr_inc;
    logic [IDW-1:0] next_ptr;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req     (req),
        .pointer (rr_ptr),
        .valid   (pick_valid),
        .index   (pick_idx)
    );

    // After a grant, the requester just served drops to lowest priority.
    assign ptr_inc  = {1'b0, pick_idx} + (IDW+1)'(1);
    assign next_ptr = (ptr_inc >= (IDW+1)'(N_REQ)) ? '0 : ptr_inc[IDW-1:0];

    // FSM, frame timer and registered outputs; requests are only looked at in IDLE.
    always_ff @(posedge clk) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            rr_ptr   <= '0;
            ack      <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            grant_id <= '0;
        end else begin
            ack      <= '0;
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        tx_data  <= req_data[pick_idx];
                        grant_id <= pick_idx;
                        ack      <= N_REQ'(1) << pick_idx;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        cnt      <= CNT_W'(1);
                        rr_ptr   <= next_ptr;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (cnt == CNT_W'(FRAME_CYCLES)) begin
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a timestamp-based model checked
// every cycle plus directed scenarios with literal expectations.
module tb_uart_tx_arbiter;

    localparam int N_REQ        = 4;
    localparam int CLKS_PER_BIT = 10;
    localparam int FRAME_BITS   = 10;
    localparam int FC           = 100;

    logic            clk = 1'b0;
    logic            RST;
    logic [3:0]      req;
    logic [3:0][7:0] req_data;
    logic [3:0]      ack;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic            busy;
    logic [1:0]      grant_id;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // model state
    bit         model_live   = 1'b0;
    bit         frame_active = 1'b0;
    int         edge_n       = 0;
    int         frame_edge   = 0;
    int         last_grant   = N_REQ - 1;
    int         winner;
    int         cand;
    logic [3:0] exp_ack;
    logic       exp_start;
    logic       exp_busy;
    logic [7:0] exp_data;
    logic [1:0] exp_gid;

    // observation log
    int         start_cyc[$];
    int         start_id[$];
    int         start_byte[$];
    logic [3:0] ack_seen = '0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ        (N_REQ),
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .FRAME_BITS   (FRAME_BITS)
    ) dut (
        .clk      (clk),
        .RST      (RST),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .busy     (busy),
        .grant_id (grant_id)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst_v, input logic [3:0] req_v, input logic [3:0][7:0] data_v);
        RST      = rst_v;
        req      = req_v;
        req_data = data_v;
    endtask

    task automatic clear_log();
        start_cyc.delete();
        start_id.delete();
        start_byte.delete();
        ack_seen = '0;
    endtask

    // Advance to the negedge of cycle 'target', optionally dropping acked requests.
    task automatic run_to(input int target, input bit drop_on_ack);
        int guard = 0;
        while (cyc < target) begin
            @(negedge clk);
            guard++;
            if (drop_on_ack) req = req & ~ack;
            if (guard > target + 10) begin
                checkOutput("run_to_timeout", cyc, target);
                break;
            end
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_start(input int i, input int c, input int id, input int b);
        if (i < start_cyc.size()) begin
            checkOutput("start_cycle", start_cyc[i], c);
            checkOutput("start_id", start_id[i], id);
            checkOutput("start_byte", start_byte[i], b);
        end
    endtask

    // Model: a frame occupies FC cycles from its tx_start; an idle cycle with
    // any request produces a grant on the next cycle, scanning after the last grant.
    always @(posedge clk) begin
        edge_n++;
        if (RST) begin
            cyc          = 0;
            model_live   = 1'b1;
            frame_active = 1'b0;
            last_grant   = N_REQ - 1;
            exp_ack      = '0;
            exp_start    = 1'b0;
            exp_busy     = 1'b0;
            exp_data     = '0;
            exp_gid      = '0;
        end else if (model_live) begin
            cyc++;
            exp_ack   = '0;
            exp_start = 1'b0;
            if ((!frame_active || (edge_n - 1 - frame_edge >= FC)) && req != 4'b0) begin
                winner = -1;
                for (int k = 1; k <= N_REQ; k++) begin
                    cand = (last_grant + k) % N_REQ;
                    if (winner < 0 && req[cand]) winner = cand;
                end
                last_grant   = winner;
                frame_active = 1'b1;
                frame_edge   = edge_n;
                exp_ack      = 4'b1 << winner;
                exp_start    = 1'b1;
                exp_data     = req_data[winner];
                exp_gid      = 2'(winner);
            end
            exp_busy = frame_active && (edge_n - frame_edge < FC);
        end
        #1;
        if (model_live) begin
            checkOutput("model_ack", ack, exp_ack);
            checkOutput("model_tx_start", tx_start, exp_start);
            checkOutput("model_busy", busy, exp_busy);
            checkOutput("model_tx_data", tx_data, exp_data);
            checkOutput("model_grant_id", grant_id, exp_gid);
            if (tx_start === 1'b1) begin
                start_cyc.push_back(cyc);
                start_id.push_back(int'(grant_id));
                start_byte.push_back(int'(tx_data));
            end
            ack_seen = ack_seen | ack;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // reset held with every request pending
        applyStimulus(1'b1, 4'b1111, {8'h44, 8'h33, 8'h22, 8'h11});
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_outputs", {ack, tx_start, busy, tx_data, grant_id}, 32'h0);
        end

        // single request, dropped on ack
        applyStimulus(1'b0, 4'b0100, {8'h00, 8'h4A, 8'h00, 8'h00});
        clear_log();
        run_to(1, 1'b1);
        checkOutput("single_tx_start", tx_start, 1'b1);
        checkOutput("single_ack", ack, 4'b0100);
        checkOutput("single_tx_data", tx_data, 8'h4A);
        checkOutput("single_grant_id", grant_id, 2'd2);
        run_to(100, 1'b1);
        checkOutput("single_busy_last", busy, 1'b1);
        run_to(101, 1'b1);
        checkOutput("single_busy_end", busy, 1'b0);
        checkOutput("single_start_count", start_cyc.size(), 1);

        // all four pending, each held until its ack
        do_reset();
        applyStimulus(1'b0, 4'b1111, {8'h44, 8'h33, 8'h22, 8'h11});
        clear_log();
        run_to(310, 1'b1);
        checkOutput("all_start_count", start_cyc.size(), 4);
        check_start(0, 1,   0, 8'h11);
        check_start(1, 102, 1, 8'h22);
        check_start(2, 203, 2, 8'h33);
        check_start(3, 304, 3, 8'h44);

        // two requesters held continuously alternate
        do_reset();
        applyStimulus(1'b0, 4'b1010, {8'hD3, 8'h00, 8'hB1, 8'h00});
        clear_log();
        run_to(410, 1'b0);
        checkOutput("alt_start_count", start_cyc.size(), 5);
        check_start(0, 1,   1, 8'hB1);
        check_start(1, 102, 3, 8'hD3);
        check_start(2, 203, 1, 8'hB1);
        check_start(3, 304, 3, 8'hD3);
        check_start(4, 405, 1, 8'hB1);

        // reset in the middle of a frame
        do_reset();
        applyStimulus(1'b0, 4'b0010, {8'h00, 8'h00, 8'h5E, 8'h00});
        run_to(50, 1'b1);
        checkOutput("midreset_busy_before", busy, 1'b1);
        RST = 1'b1;
        @(negedge clk);
        checkOutput("midreset_outputs", {ack, tx_start, busy, tx_data, grant_id}, 32'h0);
        applyStimulus(1'b0, 4'b1001, {8'h3C, 8'h00, 8'h00, 8'h0C});
        clear_log();
        run_to(110, 1'b1);
        checkOutput("midreset_start_count", start_cyc.size(), 2);
        check_start(0, 1,   0, 8'h0C);
        check_start(1, 102, 3, 8'h3C);

        // a request pulsed only during another frame is never served
        do_reset();
        applyStimulus(1'b0, 4'b0001, {8'h00, 8'h99, 8'h00, 8'h77});
        clear_log();
        run_to(20, 1'b1);
        req[2] = 1'b1;
        run_to(31, 1'b1);
        req[2] = 1'b0;
        run_to(250, 1'b1);
        checkOutput("pulse_start_count", start_cyc.size(), 1);
        check_start(0, 1, 0, 8'h77);
        checkOutput("pulse_never_acked", ack_seen[2], 1'b0);
        checkOutput("pulse_busy_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
